// File: rtl/qsys_system_pio_in_if.sv
// qsys_system_pio_in_if: Avalon-MM slave bus bundle for the input PIO
interface qsys_system_pio_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  modport master(output address, chipselect, read_n, write_n, writedata, input readdata);
  modport slave(input address, chipselect, read_n, write_n, writedata, output readdata);
endinterface

// File: rtl/qsys_system_pio_in.sv
// qsys_system_pio_in: Avalon-MM input PIO with sticky edge capture and level irq; per-bit debounce when QSYS_PIO_IN_DEBOUNCE_EN is defined
module qsys_system_pio_in #(
  parameter int WIDTH           = 4,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  qsys_system_pio_in_if.slave  av,
  input  logic [WIDTH-1:0]     in_port,
  output logic                 irq
);
  logic [WIDTH-1:0] s1_q, s2_q, f, fd_q, mask_q, mask_d, cap_q, cap_d, edge_v, clr;
  logic [31:0]      rd_q, rd_d;
  logic             rd_en, wr_en;
`ifdef QSYS_PIO_IN_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] f_q, f_d, hit;
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      hit[i]   = s2_q[i] != f_q[i] && cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1);
      f_d[i]   = hit[i] ? s2_q[i] : f_q[i];
      cnt_d[i] = (s2_q[i] == f_q[i] || hit[i]) ? '0 : cnt_q[i] + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      f_q   <= '0;
      cnt_q <= '{default: '0};
    end else begin
      f_q   <= f_d;
      cnt_q <= cnt_d;
    end
  end
  assign f = f_q;
`else
  assign f = s2_q;
`endif
  assign rd_en       = av.chipselect & ~av.read_n;
  assign wr_en       = av.chipselect & ~av.write_n;
  assign av.readdata = rd_q;
  assign irq         = |(cap_q & mask_q);
  always_comb begin
    edge_v = EDGE_TYPE == 0 ? f & ~fd_q : EDGE_TYPE == 1 ? ~f & fd_q : f ^ fd_q;
    clr    = (wr_en && av.address == 2'd3) ? av.writedata[WIDTH-1:0] : '0;
    cap_d  = (cap_q & ~clr) | edge_v;
    mask_d = (wr_en && av.address == 2'd2) ? av.writedata[WIDTH-1:0] : mask_q;
    rd_d   = !rd_en ? rd_q :
             av.address == 2'd0 ? 32'(f) :
             av.address == 2'd2 ? 32'(mask_q) :
             av.address == 2'd3 ? 32'(cap_q) : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      fd_q   <= '0;
      mask_q <= '0;
      cap_q  <= '0;
      rd_q   <= '0;
    end else begin
      s1_q   <= in_port;
      s2_q   <= s1_q;
      fd_q   <= f;
      mask_q <= mask_d;
      cap_q  <= cap_d;
      rd_q   <= rd_d;
    end
  end
endmodule

// File: tb/tb_qsys_system_pio_in.sv
// tb_qsys_system_pio_in: three PIOs (rising/falling/any) on one stimulus, table vectors plus a random run against a reference model
module tb_qsys_system_pio_in;
  localparam int DB = 16;
`ifdef QSYS_PIO_IN_DEBOUNCE_EN
  localparam int DBL = DB;
`else
  localparam int DBL = 0;
`endif
  localparam int SETTLE = 4 + DBL;

  logic        clk = 1'b0, reset = 1'b1, chipselect = 1'b0, read_n = 1'b1, write_n = 1'b1;
  logic [1:0]  address = 2'd0;
  logic [31:0] writedata = 32'd0;
  logic [3:0]  in_port = 4'd0;
  wire  [31:0] rdata [3];
  wire  [2:0]  irq;
  int          n_cmp = 0, n_bad = 0;
  logic        chk_en = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : u
    qsys_system_pio_in_if bus();
    assign bus.address    = address;
    assign bus.chipselect = chipselect;
    assign bus.read_n     = read_n;
    assign bus.write_n    = write_n;
    assign bus.writedata  = writedata;
    assign rdata[g]       = bus.readdata;
    qsys_system_pio_in #(.WIDTH(4), .EDGE_TYPE(g), .DEBOUNCE_CYCLES(DB)) dut (
      .clk(clk), .reset(reset), .av(bus), .in_port(in_port), .irq(irq[g]));
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference model: the filtered value is the synchronized input, or with
  // debounce it flips only once the last DB synchronized samples all disagree.
  logic [3:0]  m_s1, m_s2, m_fq, m_fd, m_mask;
  logic [3:0]  m_cap [3];
  logic [31:0] m_rd [3];
  logic [3:0]  hist [$];

  function automatic logic [3:0] mf();
`ifdef QSYS_PIO_IN_DEBOUNCE_EN
    return m_fq;
`else
    return m_s2;
`endif
  endfunction

  function automatic logic [3:0] filt();
    logic [3:0] r;
    bit flip;
    r = m_fq;
    if (hist.size() == DB)
      for (int i = 0; i < 4; i++) begin
        flip = 1'b1;
        foreach (hist[j]) if (hist[j][i] == m_fq[i]) flip = 1'b0;
        if (flip) r[i] = ~m_fq[i];
      end
    return r;
  endfunction

  function automatic logic [31:0] regv(input int g, input logic [1:0] a);
    return a == 2'd0 ? {28'd0, mf()} : a == 2'd2 ? {28'd0, m_mask} : a == 2'd3 ? {28'd0, m_cap[g]} : 32'd0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_s1 <= '0; m_s2 <= '0; m_fq <= '0; m_fd <= '0; m_mask <= '0;
      for (int g = 0; g < 3; g++) begin
        m_cap[g] <= '0;
        m_rd[g]  <= '0;
      end
      hist.delete();
    end else begin
      for (int g = 0; g < 3; g++) begin
        if (chipselect && !read_n) m_rd[g] <= regv(g, address);
        m_cap[g] <= (m_cap[g] & ~((chipselect && !write_n && address == 2'd3) ? writedata[3:0] : 4'd0)) |
                    (g == 0 ? mf() & ~m_fd : g == 1 ? ~mf() & m_fd : mf() ^ m_fd);
      end
      if (chipselect && !write_n && address == 2'd2) m_mask <= writedata[3:0];
      hist.push_back(m_s2);
      if (hist.size() > DB) void'(hist.pop_front());
      m_fq <= filt();
      m_fd <= mf();
      m_s2 <= m_s1;
      m_s1 <= in_port;
    end
  end

  always @(negedge clk)
    if (chk_en)
      for (int g = 0; g < 3; g++) begin
        chk($sformatf("model rd dut%0d", g), rdata[g], m_rd[g]);
        chk($sformatf("model irq dut%0d", g), {31'd0, irq[g]}, {31'd0, |(m_cap[g] & m_mask)});
      end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic bus_op(input logic wr, input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; read_n = wr; write_n = !wr;
    cyc();
    chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
  endtask

  // Expected values are packed {any, fall, rise}, i.e. index g = EDGE_TYPE.
  task automatic exp_rd(input string nm, input logic [2:0][3:0] e);
    for (int g = 0; g < 3; g++) chk($sformatf("%s dut%0d", nm, g), rdata[g], {28'd0, e[g]});
  endtask

  task automatic exp_irq(input string nm, input logic [2:0] e);
    for (int g = 0; g < 3; g++) chk($sformatf("%s dut%0d", nm, g), {31'd0, irq[g]}, {31'd0, e[g]});
  endtask

  typedef struct {
    logic [3:0]      inp;
    logic            wr;
    logic [1:0]      addr;
    logic [31:0]     wd;
    logic [2:0][3:0] exp_rd;
    logic [2:0]      exp_irq;
  } vec_t;
  vec_t tbl [23];

  initial begin
    int hold;
    tbl = '{
      '{4'h0, 1'b0, 2'd0, 32'h0, 12'h000, 3'b000},
      '{4'h0, 1'b0, 2'd1, 32'h0, 12'h000, 3'b000},
      '{4'h0, 1'b0, 2'd2, 32'h0, 12'h000, 3'b000},
      '{4'h0, 1'b0, 2'd3, 32'h0, 12'h000, 3'b000},
      '{4'h0, 1'b1, 2'd2, 32'hF, 12'h000, 3'b000},
      '{4'h5, 1'b0, 2'd0, 32'h0, 12'h555, 3'b101},
      '{4'h5, 1'b0, 2'd3, 32'h0, 12'h505, 3'b101},
      '{4'h5, 1'b1, 2'd3, 32'h1, 12'h000, 3'b101},
      '{4'h5, 1'b0, 2'd3, 32'h0, 12'h404, 3'b101},
      '{4'h5, 1'b1, 2'd3, 32'h4, 12'h000, 3'b000},
      '{4'h5, 1'b0, 2'd2, 32'h0, 12'hFFF, 3'b000},
      '{4'h5, 1'b1, 2'd2, 32'h2, 12'h000, 3'b000},
      '{4'h4, 1'b0, 2'd3, 32'h0, 12'h110, 3'b000},
      '{4'h4, 1'b1, 2'd3, 32'hF, 12'h000, 3'b000},
      '{4'h5, 1'b0, 2'd3, 32'h0, 12'h101, 3'b000},
      '{4'h5, 1'b1, 2'd2, 32'h3, 12'h000, 3'b101},
      '{4'h5, 1'b1, 2'd0, 32'hA, 12'h000, 3'b101},
      '{4'h5, 1'b0, 2'd0, 32'h0, 12'h555, 3'b101},
      '{4'h5, 1'b1, 2'd1, 32'hF, 12'h000, 3'b101},
      '{4'h5, 1'b0, 2'd1, 32'h0, 12'h000, 3'b101},
      '{4'h5, 1'b1, 2'd3, 32'hF, 12'h000, 3'b000},
      '{4'h7, 1'b0, 2'd3, 32'h0, 12'h202, 3'b101},
      '{4'h5, 1'b0, 2'd3, 32'h0, 12'h222, 3'b111}
    };
    repeat (3) cyc();
    reset = 1'b0;
    chk_en = 1'b1;
    exp_irq("reset irq", 3'b000);
    foreach (tbl[i]) begin
      in_port = tbl[i].inp;
      repeat (SETTLE) cyc();
      bus_op(tbl[i].wr, tbl[i].addr, tbl[i].wd);
      if (!tbl[i].wr) exp_rd($sformatf("row%0d rd", i), tbl[i].exp_rd);
      exp_irq($sformatf("row%0d irq", i), tbl[i].exp_irq);
    end
    // bit3 rises in the very cycle that a clear of bit3 is written
    bus_op(1'b1, 2'd3, 32'hF);
    in_port = 4'hD;
    repeat (2 + DBL) cyc();
    bus_op(1'b1, 2'd3, 32'h8);
    bus_op(1'b0, 2'd3, 32'h0);
    exp_rd("collide", 12'h808);
    bus_op(1'b1, 2'd3, 32'h8);
    bus_op(1'b0, 2'd3, 32'h0);
    exp_rd("clear bit3", 12'h000);
    in_port = 4'h1;
    reset = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    repeat (SETTLE) cyc();
    bus_op(1'b0, 2'd3, 32'h0);
    exp_rd("held high cap", 12'h101);
    exp_irq("held high irq", 3'b000);
    bus_op(1'b0, 2'd2, 32'h0);
    exp_rd("held high mask", 12'h000);
`ifdef QSYS_PIO_IN_DEBOUNCE_EN
    in_port = 4'h0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    repeat (SETTLE) cyc();
    in_port = 4'h1;
    repeat (10) cyc();
    in_port = 4'h0;
    repeat (SETTLE) cyc();
    bus_op(1'b0, 2'd0, 32'h0);
    exp_rd("glitch data", 12'h000);
    bus_op(1'b0, 2'd3, 32'h0);
    exp_rd("glitch cap", 12'h000);
    in_port = 4'h1;
    repeat (17) cyc();
    bus_op(1'b0, 2'd0, 32'h0);
    exp_rd("db data early", 12'h000);
    bus_op(1'b0, 2'd0, 32'h0);
    exp_rd("db data", 12'h111);
    bus_op(1'b0, 2'd3, 32'h0);
    exp_rd("db cap", 12'h101);
    in_port = 4'h0;
    repeat (SETTLE) cyc();
    in_port = 4'h2;
    repeat (10) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    repeat (17) cyc();
    bus_op(1'b0, 2'd0, 32'h0);
    exp_rd("db reset early", 12'h000);
    bus_op(1'b0, 2'd0, 32'h0);
    exp_rd("db reset data", 12'h222);
`endif
    hold = 0;
    repeat (3000) begin
      if (hold == 0) begin
        in_port = 4'($urandom);
        hold = int'($urandom_range(1, 2 * DBL + 6));
      end
      hold--;
      reset      = $urandom_range(0, 299) == 0;
      chipselect = $urandom_range(0, 3) != 0;
      read_n     = 1'($urandom_range(0, 1));
      write_n    = $urandom_range(0, 2) != 0;
      address    = 2'($urandom);
      writedata  = $urandom;
      cyc();
    end
    reset = 1'b0; chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
    repeat (4) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
